// File: rtl/pre_if_fetch_ctrl_pkg.sv
// Shared constants, types and helpers for the pre-IF fetch controller.
// The optional PFS_PERF_CNT_EN build adds accept/discard performance counters to the top.
package pre_if_fetch_ctrl_pkg;

  localparam logic [31:0] PFS_RESET_PC      = 32'h1c000000;
  localparam int          PFS_PC_W          = 32;
  localparam int          PFS_TO_FS_BUS_WD  = PFS_PC_W + 1;

  // Record handed to IF for every accepted request: fetch PC plus address-error flag.
  typedef struct packed {
    logic [PFS_PC_W-1:0] pc;
    logic                adef;
  } pfs_to_fs_bus_t;

  function automatic logic pc_misaligned(input logic [PFS_PC_W-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pre_if_fetch_ctrl_outst_tracker.sv
// Outstanding-request and stale-response bookkeeping for the pre-IF fetch controller.
// Counts in-flight requests and flags responses that belong to fetches made before a redirect.
module pre_if_fetch_ctrl_outst_tracker
  import pre_if_fetch_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic             data_ok,
  input  logic             redirect_valid,
  output logic             full,
  output logic             fs_discard,
  output logic [CNT_W-1:0] outst_cnt
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] cancel_cnt;
  logic             dec;

  // A response with nothing outstanding is illegal; ignoring it keeps the counters at zero.
  assign dec        = data_ok & (outst_cnt != '0);
  assign full       = outst_cnt >= MAX_C;
  assign fs_discard = data_ok & ((cancel_cnt != '0) | redirect_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      outst_cnt  <= '0;
      cancel_cnt <= '0;
    end else begin
      case ({accept, dec})
        2'b10:   outst_cnt <= outst_cnt + CNT_W'(1);
        2'b01:   outst_cnt <= outst_cnt - CNT_W'(1);
        default: outst_cnt <= outst_cnt;
      endcase
      // Everything still in flight at the redirect is stale; a same-cycle accept is not.
      if (redirect_valid) begin
        cancel_cnt <= outst_cnt - CNT_W'(dec);
      end else if (data_ok && cancel_cnt != '0) begin
        cancel_cnt <= cancel_cnt - CNT_W'(1);
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(data_ok && outst_cnt == '0))
    else $error("pre_if_fetch_ctrl: data_ok with no outstanding request");

endmodule

// File: rtl/pre_if_fetch_ctrl.sv
// Pre-IF fetch controller: next-PC selection, redirect capture and the inst_sram request channel.
// Define PFS_PERF_CNT_EN to add perf_req_cnt / perf_discard_cnt outputs.
module pre_if_fetch_ctrl
  import pre_if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PFS_RESET_PC,
  parameter int          MAX_OUTST = 4,
  parameter int          CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fs_allowin,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic             br_stall,
  output logic             inst_sram_req,
  output logic [31:0]      inst_sram_addr,
  input  logic             inst_sram_addr_ok,
  input  logic             inst_sram_data_ok,
  output logic             pfs_to_fs_valid,
  output logic [31:0]      pfs_to_fs_pc,
  output logic             pfs_to_fs_adef,
  output logic             fs_discard,
  output logic [CNT_W-1:0] outst_cnt
`ifdef PFS_PERF_CNT_EN
  ,
  output logic [31:0]      perf_req_cnt,
  output logic [31:0]      perf_discard_cnt
`endif
);

  logic [31:0]    pc_r;
  logic [31:0]    redir_tgt_r;
  logic           redir_pend;
  logic           valid_r;
  logic [31:0]    nextpc;
  logic           full;
  logic           accept;
  pfs_to_fs_bus_t fs_bus;

  // A live redirect wins over a captured one, which wins over sequential fetch.
  always_comb begin
    nextpc = pc_r + 32'd4;
    if (redirect_valid) begin
      nextpc = redirect_target;
    end else if (redir_pend) begin
      nextpc = redir_tgt_r;
    end
  end

  assign inst_sram_req  = valid_r & fs_allowin & ~br_stall & ~full;
  assign inst_sram_addr = nextpc;
  assign accept         = inst_sram_req & inst_sram_addr_ok;

  assign fs_bus.pc      = nextpc;
  assign fs_bus.adef    = pc_misaligned(nextpc);

  assign pfs_to_fs_valid = accept;
  assign pfs_to_fs_pc    = fs_bus.pc;
  assign pfs_to_fs_adef  = fs_bus.adef;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r        <= RESET_PC - 32'd4;
      redir_pend  <= 1'b0;
      redir_tgt_r <= '0;
      valid_r     <= 1'b0;
    end else begin
      valid_r <= 1'b1;
      if (accept) begin
        pc_r <= nextpc;
      end
      // Hold an unaccepted redirect so the target survives until the bus takes it.
      if (redirect_valid && !accept) begin
        redir_pend  <= 1'b1;
        redir_tgt_r <= redirect_target;
      end else if (accept) begin
        redir_pend <= 1'b0;
      end
    end
  end

  pre_if_fetch_ctrl_outst_tracker #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_pfs_outst_tracker (
    .clk            (clk),
    .reset          (reset),
    .accept         (accept),
    .data_ok        (inst_sram_data_ok),
    .redirect_valid (redirect_valid),
    .full           (full),
    .fs_discard     (fs_discard),
    .outst_cnt      (outst_cnt)
  );

`ifdef PFS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_req_cnt     <= '0;
      perf_discard_cnt <= '0;
    end else begin
      if (accept) begin
        perf_req_cnt <= perf_req_cnt + 32'd1;
      end
      if (fs_discard) begin
        perf_discard_cnt <= perf_discard_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pre_if_fetch_ctrl.sv
// Directed testbench for pre_if_fetch_ctrl with hand-computed expectations.
// Optional PFS_PERF_CNT_EN ports are connected when the macro is defined.
module tb_pre_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fs_allowin = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        br_stall = 1'b0;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic        pfs_to_fs_valid;
  logic [31:0] pfs_to_fs_pc;
  logic        pfs_to_fs_adef;
  logic        fs_discard;
  logic [3:0]  outst_cnt;
`ifdef PFS_PERF_CNT_EN
  logic [31:0] perf_req_cnt;
  logic [31:0] perf_discard_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pre_if_fetch_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .fs_allowin        (fs_allowin),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .br_stall          (br_stall),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .pfs_to_fs_valid   (pfs_to_fs_valid),
    .pfs_to_fs_pc      (pfs_to_fs_pc),
    .pfs_to_fs_adef    (pfs_to_fs_adef),
    .fs_discard        (fs_discard),
    .outst_cnt         (outst_cnt)
`ifdef PFS_PERF_CNT_EN
    ,
    .perf_req_cnt      (perf_req_cnt),
    .perf_discard_cnt  (perf_discard_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    fs_allowin        = 1'b0;
    redirect_valid    = 1'b0;
    br_stall          = 1'b0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    fs_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    tick();
    tick();
    #1;
    total++;
    if (inst_sram_req !== 1'b0) begin
      bad++; $display("FAIL reset_req: got %0b want 0", inst_sram_req);
    end
    total++;
    if (pfs_to_fs_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %0b want 0", pfs_to_fs_valid);
    end
    total++;
    if (fs_discard !== 1'b0 || outst_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_cnt: discard=%0b outst=%0d want 0/0", fs_discard, outst_cnt);
    end
    total++;
    if (inst_sram_addr !== 32'h1c000000) begin
      bad++; $display("FAIL reset_addr: got %h want 1c000000", inst_sram_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequential;
    fs_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      inst_sram_data_ok = (i != 0);
      #1;
      total++;
      if (pfs_to_fs_valid !== 1'b1 || inst_sram_addr !== 32'h1c000000 + 32'(4 * i) ||
          pfs_to_fs_pc !== 32'h1c000000 + 32'(4 * i)) begin
        bad++; $display("FAIL seq_addr%0d: valid=%0b addr=%h pc=%h want 1/%h", i, pfs_to_fs_valid,
                        inst_sram_addr, pfs_to_fs_pc, 32'h1c000000 + 32'(4 * i));
      end
      total++;
      if (outst_cnt > 4'd1 || fs_discard !== 1'b0) begin
        bad++; $display("FAIL seq_outst%0d: outst=%0d discard=%0b want <=1/0", i, outst_cnt, fs_discard);
      end
      tick();
    end
    fs_allowin = 1'b0;
    inst_sram_data_ok = 1'b1;
    tick();
    inst_sram_data_ok = 1'b0;
    total++;
    if (outst_cnt !== 4'd0) begin
      bad++; $display("FAIL seq_drain: outst=%0d want 0", outst_cnt);
    end
  endtask

  task automatic test_full;
    int accepts = 0;
    fs_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (pfs_to_fs_valid === 1'b1) accepts++;
      tick();
    end
    total++;
    if (accepts != 4 || outst_cnt !== 4'd4 || inst_sram_req !== 1'b0) begin
      bad++; $display("FAIL full_limit: accepts=%0d outst=%0d req=%0b want 4/4/0", accepts, outst_cnt, inst_sram_req);
    end
    inst_sram_data_ok = 1'b1;
    #1;
    total++;
    if (inst_sram_req !== 1'b0 || fs_discard !== 1'b0) begin
      bad++; $display("FAIL full_nobypass: req=%0b discard=%0b want 0/0", inst_sram_req, fs_discard);
    end
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    total++;
    if (outst_cnt !== 4'd3 || inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00001c) begin
      bad++; $display("FAIL full_resume: outst=%0d req=%0b addr=%h want 3/1/1c00001c", outst_cnt, inst_sram_req, inst_sram_addr);
    end
    tick();
    fs_allowin = 1'b0;
    inst_sram_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (fs_discard !== 1'b0) begin
        bad++; $display("FAIL full_drain%0d: discard=%0b want 0", i, fs_discard);
      end
      tick();
    end
    inst_sram_data_ok = 1'b0;
    total++;
    if (outst_cnt !== 4'd0) begin
      bad++; $display("FAIL full_empty: outst=%0d want 0", outst_cnt);
    end
  endtask

  task automatic test_redirect_cancel;
    fs_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    tick(); tick(); tick();
    total++;
    if (outst_cnt !== 4'd3) begin
      bad++; $display("FAIL rdc_setup: outst=%0d want 3", outst_cnt);
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h1c000100;
    #1;
    total++;
    if (pfs_to_fs_valid !== 1'b1 || pfs_to_fs_pc !== 32'h1c000100 || inst_sram_addr !== 32'h1c000100) begin
      bad++; $display("FAIL rdc_issue: valid=%0b pc=%h addr=%h want 1/1c000100", pfs_to_fs_valid, pfs_to_fs_pc, inst_sram_addr);
    end
    tick();
    redirect_valid = 1'b0;
    fs_allowin = 1'b0;
    inst_sram_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (fs_discard !== (i < 3)) begin
        bad++; $display("FAIL rdc_discard%0d: got %0b want %0b", i, fs_discard, (i < 3));
      end
      tick();
    end
    inst_sram_data_ok = 1'b0;
    total++;
    if (outst_cnt !== 4'd0) begin
      bad++; $display("FAIL rdc_empty: outst=%0d want 0", outst_cnt);
    end
  endtask

  task automatic test_redirect_hold;
    fs_allowin = 1'b1;
    inst_sram_addr_ok = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h1c000100;
    #1;
    total++;
    if (inst_sram_addr !== 32'h1c000100 || pfs_to_fs_valid !== 1'b0) begin
      bad++; $display("FAIL hold_first: addr=%h valid=%0b want 1c000100/0", inst_sram_addr, pfs_to_fs_valid);
    end
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin
        bad++; $display("FAIL hold_wait%0d: req=%0b addr=%h want 1/1c000100", i, inst_sram_req, inst_sram_addr);
      end
      tick();
    end
    inst_sram_addr_ok = 1'b1;
    #1;
    total++;
    if (pfs_to_fs_valid !== 1'b1 || pfs_to_fs_pc !== 32'h1c000100) begin
      bad++; $display("FAIL hold_accept: valid=%0b pc=%h want 1/1c000100", pfs_to_fs_valid, pfs_to_fs_pc);
    end
    tick();
    fs_allowin = 1'b0;
    #1;
    total++;
    if (inst_sram_addr !== 32'h1c000104) begin
      bad++; $display("FAIL hold_cleared: addr=%h want 1c000104", inst_sram_addr);
    end
    inst_sram_data_ok = 1'b1;
    #1;
    total++;
    if (fs_discard !== 1'b0) begin
      bad++; $display("FAIL hold_resp: discard=%0b want 0", fs_discard);
    end
    tick();
    inst_sram_data_ok = 1'b0;
  endtask

  task automatic test_redirect_dataok;
    fs_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    tick(); tick();
    fs_allowin = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h1c000180;
    inst_sram_data_ok = 1'b1;
    #1;
    total++;
    if (outst_cnt !== 4'd2 || fs_discard !== 1'b1) begin
      bad++; $display("FAIL rdo_same: outst=%0d discard=%0b want 2/1", outst_cnt, fs_discard);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    total++;
    if (outst_cnt !== 4'd1 || fs_discard !== 1'b1) begin
      bad++; $display("FAIL rdo_next: outst=%0d discard=%0b want 1/1", outst_cnt, fs_discard);
    end
    tick();
    inst_sram_data_ok = 1'b0;
    fs_allowin = 1'b1;
    #1;
    total++;
    if (pfs_to_fs_valid !== 1'b1 || pfs_to_fs_pc !== 32'h1c000180) begin
      bad++; $display("FAIL rdo_pend: valid=%0b pc=%h want 1/1c000180", pfs_to_fs_valid, pfs_to_fs_pc);
    end
    tick();
    fs_allowin = 1'b0;
    inst_sram_data_ok = 1'b1;
    #1;
    total++;
    if (fs_discard !== 1'b0) begin
      bad++; $display("FAIL rdo_fresh: discard=%0b want 0", fs_discard);
    end
    tick();
    inst_sram_data_ok = 1'b0;
  endtask

  task automatic test_br_stall;
    fs_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    br_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (inst_sram_req !== 1'b0 || pfs_to_fs_valid !== 1'b0) begin
        bad++; $display("FAIL stall%0d: req=%0b valid=%0b want 0/0", i, inst_sram_req, pfs_to_fs_valid);
      end
      tick();
    end
    br_stall = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h1c000200;
    #1;
    total++;
    if (pfs_to_fs_valid !== 1'b1 || pfs_to_fs_pc !== 32'h1c000200 || pfs_to_fs_adef !== 1'b0) begin
      bad++; $display("FAIL stall_release: valid=%0b pc=%h adef=%0b want 1/1c000200/0", pfs_to_fs_valid, pfs_to_fs_pc, pfs_to_fs_adef);
    end
    tick();
    redirect_valid = 1'b0;
    fs_allowin = 1'b0;
    inst_sram_data_ok = 1'b1;
    tick();
    inst_sram_data_ok = 1'b0;
  endtask

  task automatic test_adef;
    fs_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h1c000102;
    #1;
    total++;
    if (pfs_to_fs_valid !== 1'b1 || pfs_to_fs_pc !== 32'h1c000102 || pfs_to_fs_adef !== 1'b1) begin
      bad++; $display("FAIL adef: valid=%0b pc=%h adef=%0b want 1/1c000102/1", pfs_to_fs_valid, pfs_to_fs_pc, pfs_to_fs_adef);
    end
    tick();
    redirect_valid = 1'b0;
    fs_allowin = 1'b0;
    inst_sram_data_ok = 1'b1;
    tick();
    inst_sram_data_ok = 1'b0;
  endtask

  task automatic test_reset_mid;
    fs_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    #1;
    total++;
    if (outst_cnt !== 4'd0 || inst_sram_req !== 1'b0 || inst_sram_addr !== 32'h1c000000) begin
      bad++; $display("FAIL reset_mid: outst=%0d req=%0b addr=%h want 0/0/1c000000", outst_cnt, inst_sram_req, inst_sram_addr);
    end
    reset = 1'b0;
    tick();
    #1;
    total++;
    if (pfs_to_fs_valid !== 1'b1 || pfs_to_fs_pc !== 32'h1c000000) begin
      bad++; $display("FAIL reset_mid_restart: valid=%0b pc=%h want 1/1c000000", pfs_to_fs_valid, pfs_to_fs_pc);
    end
    fs_allowin = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_redirect_cancel();
    test_redirect_hold();
    test_redirect_dataok();
    test_br_stall();
    test_adef();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
